rom_fetch: RTL and testbench

ROM_FETCH -- requirements
Module: rom_fetch

---
 rtl/rom_fetch_pkg.sv | 21 ++
 rtl/rom_fetch_if.sv | 41 ++++
 rtl/rom_fetch.sv | 135 +++++++++++++
 tb/tb_rom_fetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch_pkg
//  Description : Shared types and widths for the one-word ROM fetch cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_fetch_pkg;

  localparam int WORD_W  = 32;
  localparam int WADDR_W = 9;
  localparam int LANE_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rom_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch_if
//  Description : Request/response and SRAM read-port bundle for rom_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_fetch_if #(
  parameter int ADDR_W = 11
);
  import rom_fetch_pkg::*;

  logic                flush;
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [7:0]          rsp_data;
  logic                oram_csb;
  logic [WADDR_W-1:0]  oram_addr;
  logic [WORD_W-1:0]   oram_value;

  // Consumer side: issues fetches and accepts opcode bytes.
  modport master (
    output flush, req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Fetch unit side, including its SRAM read port.
  modport slave (
    input  flush, req_valid, req_addr, rsp_ready, oram_value,
    output req_ready, rsp_valid, rsp_data, oram_csb, oram_addr
  );

  modport sram (
    input  oram_csb, oram_addr,
    output oram_value
  );

endinterface
`default_nettype wire

// File: rtl/rom_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch
//  Description : Opcode-byte fetcher with a single cached 32-bit program word.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_fetch
  import rom_fetch_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int READ_WAIT = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [7:0]          rsp_data_o,
  output logic                oram_csb,
  output logic [WADDR_W-1:0]  oram_addr,
  input  logic [WORD_W-1:0]   oram_value
);

  localparam int                 c_cnt_w = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = (READ_WAIT > 0) ? c_cnt_w'(READ_WAIT - 1) : '0;

  state_e               r_state;
  logic                 r_valid;
  logic [WADDR_W-1:0]   r_tag;
  logic [WORD_W-1:0]    r_data;
  logic                 r_fill_ok;
  logic [LANE_W-1:0]    r_lane;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_rsp_valid;
  logic [7:0]           r_rsp_data;
  logic                 r_csb;
  logic [WADDR_W-1:0]   r_oaddr;

  logic                 w_req_ready;
  logic                 w_accept;
  logic [WADDR_W-1:0]   w_word;
  logic [LANE_W-1:0]    w_lane;
  logic                 w_hit;
  logic                 w_fill_done;
  logic [7:0]           w_hit_byte;
  logic [7:0]           w_fill_byte;

  assign w_req_ready = !wb_rst_i &&
                       ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready_i));
  assign w_accept    = req_valid_i && w_req_ready;
  assign w_word      = req_addr_i[WADDR_W+LANE_W-1:LANE_W];
  assign w_lane      = req_addr_i[LANE_W-1:0];
  assign w_hit       = r_valid && (r_tag == w_word) && !flush_i;
  assign w_fill_done = ((r_state == ST_WAIT) && (r_cnt == c_last)) ||
                       ((READ_WAIT == 0) && (r_state == ST_READ));
  assign w_hit_byte  = r_data[{w_lane, 3'b000} +: 8];
  assign w_fill_byte = oram_value[{r_lane, 3'b000} +: 8];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_valid     <= 1'b0;
      r_tag       <= '0;
      r_data      <= '0;
      r_fill_ok   <= 1'b0;
      r_lane      <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_csb       <= 1'b1;
      r_oaddr     <= '0;
    end else begin
      r_csb <= 1'b1;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (flush_i) begin
            r_valid <= 1'b0;
          end
          if (w_accept) begin
            if (w_hit) begin
              r_rsp_data  <= w_hit_byte;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              // The line is being replaced; it only becomes valid again when
              // the fill completes without an intervening flush.
              r_valid     <= 1'b0;
              r_fill_ok   <= 1'b1;
              r_csb       <= 1'b0;
              r_oaddr     <= w_word;
              r_lane      <= w_lane;
              r_rsp_valid <= 1'b0;
              r_state     <= ST_READ;
            end
          end else if ((r_state == ST_RESP) && rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_READ, ST_WAIT: begin
          if (w_fill_done) begin
            r_data      <= oram_value;
            r_tag       <= r_oaddr;
            r_valid     <= r_fill_ok && !flush_i;
            r_rsp_data  <= w_fill_byte;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            if (flush_i) begin
              r_fill_ok <= 1'b0;
            end
            if (r_state == ST_READ) begin
              r_cnt   <= '0;
              r_state <= ST_WAIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = w_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign oram_csb    = r_csb;
  assign oram_addr   = r_oaddr;

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_fetch
//  Description : Scoreboard bench for rom_fetch against a timestamped cache model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_fetch;
  import rom_fetch_pkg::*;

  localparam int RW = 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rdy_mode = 0;

  logic [31:0] mem [512];
  rsp_t        sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_fetch_if #(.ADDR_W(11)) bus ();

  rom_fetch #(.ADDR_W(11), .READ_WAIT(RW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .flush_i    (bus.flush),
    .req_valid_i(bus.req_valid),
    .req_ready_o(bus.req_ready),
    .req_addr_i (bus.req_addr),
    .rsp_valid_o(bus.rsp_valid),
    .rsp_ready_i(bus.rsp_ready),
    .rsp_data_o (bus.rsp_data),
    .oram_csb   (bus.oram_csb),
    .oram_addr  (bus.oram_addr),
    .oram_value (bus.oram_value)
  );

  // Synchronous SRAM: data appears the cycle after a selected edge.
  always @(posedge clk) if (bus.oram_csb === 1'b0) bus.oram_value <= mem[bus.oram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] exp_byte(input logic [10:0] a);
    logic [31:0] w;
    w = mem[a[10:2]];
    return 8'(w >> (8 * a[1:0]));
  endfunction

  // Reference model: cache line plus the timestamp at which each event is due.
  logic       m_en = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_valid = 1'b0;
  logic [8:0] m_tag = '0;
  logic [8:0] m_oaddr = '0;
  int         m_due = 0;
  int         m_csb_cyc = -1;
  logic       exp_rv, exp_rdy, old_valid;
  logic [8:0] req_w;

  always @(negedge clk) begin
    exp_rv  = m_busy && (cyc >= m_due);
    exp_rdy = !rst && (!m_busy || (exp_rv && bus.rsp_ready));
    if (m_en) begin
      check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      check("oram_csb", 32'(bus.oram_csb), 32'(cyc != m_csb_cyc));
      check("oram_addr", 32'(bus.oram_addr), 32'(m_oaddr));
    end
    if (rst) begin
      m_busy    = 1'b0;
      m_valid   = 1'b0;
      m_oaddr   = '0;
      m_csb_cyc = -1;
      m_en      = 1'b1;
    end else begin
      if (exp_rv && bus.rsp_ready) m_busy = 1'b0;
      old_valid = m_valid;
      if (bus.flush) m_valid = 1'b0;
      if (bus.req_valid && exp_rdy) begin
        req_w = bus.req_addr[10:2];
        if (old_valid && (m_tag == req_w) && !bus.flush) begin
          m_due = cyc + 1;
        end else begin
          m_due     = cyc + 2 + RW;
          m_csb_cyc = cyc + 1;
          m_oaddr   = req_w;
          m_tag     = req_w;
          m_valid   = 1'b1;
        end
        sb.push_back('{data: exp_byte(bus.req_addr), cyc: m_due});
        m_busy = 1'b1;
      end
    end
  end

  // Monitor: compares each presented response against the scoreboard head.
  logic       mon_held = 1'b0;
  logic [7:0] mon_data = '0;

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (!mon_held) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL rsp_unexpected: got byte 0x%0h, expected no response (cycle %0d)", bus.rsp_data, cyc);
        end else begin
          check("rsp_data", 32'(bus.rsp_data), 32'(sb[0].data));
          check("rsp_cycle", 32'(cyc), 32'(sb[0].cyc));
        end
        mon_data = bus.rsp_data;
      end else begin
        check("rsp_hold", 32'(bus.rsp_data), 32'(mon_data));
      end
      if (bus.rsp_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        mon_held = 1'b0;
      end else begin
        mon_held = 1'b1;
      end
    end else begin
      mon_held = 1'b0;
    end
    if (rst) begin
      sb.delete();
      mon_held = 1'b0;
    end
  end

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = ($urandom_range(0, 9) < 7);
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic do_req(input logic [10:0] a, input logic f);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.flush     = f;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.req_ready !== 1'b1) && (n < 200));
    if (bus.req_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL req_accept: req_ready stayed low for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    if (m_busy) begin
      n_checks++;
      $display("FAIL wait_idle: response outstanding after %0d cycles, expected drained", n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [8:0] w;
    int         r;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[5] = 32'h1A2B3C4D;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'h00);
    @(posedge clk);
    #1;

    do_req(11'h014, 1'b0);
    wait_idle();
    do_req(11'h017, 1'b0);
    wait_idle();

    rdy_mode = 2;
    do_req(11'h015, 1'b0);
    fork
      do_req(11'h016, 1'b0);
      begin
        repeat (5) @(negedge clk);
        rdy_mode = 0;
      end
    join
    wait_idle();

    do_req(11'h7FC, 1'b0);
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    wait_idle();
    do_req(11'h7FD, 1'b0);
    wait_idle();

    do_req(11'h014, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_req(11'h014, 1'b0);
    wait_idle();

    do_req(11'h014, 1'b0);
    do_req(11'h015, 1'b0);
    do_req(11'h016, 1'b0);
    do_req(11'h017, 1'b0);
    wait_idle();

    rdy_mode = 1;
    for (int k = 0; k < 300; k++) begin
      w = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(4, 7));
      r = $urandom_range(0, 19);
      if (r == 0) begin
        wait_idle();
        mem[w]    = $urandom;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
      end else begin
        do_req({w, 2'($urandom_range(0, 3))}, ($urandom_range(0, 9) == 0));
      end
    end
    rdy_mode = 0;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
